motor_speed_ramp: RTL and testbench

Acceleration and direction-reversal limiter between the balance/steering control loop and one stepper motor driver. Takes the control loop's signed 10-bit target speed, slews an internal speed toward it by a bounded step per update tick, and enforces a zero-speed dwell before any direction reversal. Drives the motor driver's direction, speed-magnitude and run-enable inputs. One instance per wheel (left, right).

---
 rtl/motor_pkg.sv | 15 +
 rtl/motor_speed_ramp_if.sv | 24 ++
 rtl/tick_divider.sv | 26 ++
 rtl/motor_speed_ramp.sv | 126 ++++++++++++
 tb/tb_motor_speed_ramp.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/motor_pkg.sv
// Shared motor-control definitions: speed width, limits and ramp state encoding.
package motor_pkg;

  localparam int   MOTOR_SPEED_W = 10;
  localparam int   SPEED_MAX     = 511;
  localparam logic DIR_FWD       = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2,
    ESTOP = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/motor_speed_ramp_if.sv
// Control-loop side command and motor-driver side status of one speed ramp.
interface motor_speed_ramp_if;
  import motor_pkg::*;

  logic                            enable;
  logic                            estop;
  logic signed [MOTOR_SPEED_W-1:0] target;
  logic        [MOTOR_SPEED_W-1:0] speed;
  logic                            dir;
  logic                            run_en;
  logic                            at_target;
  logic                            tick;

  modport master (
    output enable, estop, target,
    input  speed, dir, run_en, at_target, tick
  );

  modport slave (
    input  enable, estop, target,
    output speed, dir, run_en, at_target, tick
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running divider; registered tick is high while the count sits at DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == CW'(DIV - 1)) count <= '0;
      else                       count <= count + CW'(1);
      // registered so tick lines up with count == DIV-1 without a comb output path
      tick <= (count == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/motor_speed_ramp.sv
// Slew and reversal limiter between the control loop and one stepper driver.
//   state | meaning
//   IDLE  | cur = 0, waiting for a nonzero effective target
//   RAMP  | cur != 0, slewing toward eff (or toward 0 on reversal)
//   DWELL | cur = 0, holding for DWELL_TICKS ticks before any restart
//   ESTOP | cur forced to 0 while estop is held
module motor_speed_ramp
  import motor_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MAX_STEP    = 8,
  parameter int unsigned DWELL_TICKS = 2
) (
  input logic               clock,
  input logic               reset,
  motor_speed_ramp_if.slave bus
);

  localparam int W  = MOTOR_SPEED_W;
  localparam int DW = $clog2(DWELL_TICKS + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RAMP  = RAMP;
  localparam logic [1:0] S_DWELL = DWELL;
  localparam logic [1:0] S_ESTOP = ESTOP;

  localparam logic signed [W-1:0] LIM        = W'(SPEED_MAX);
  localparam logic signed [W-1:0] STEP_N     = W'(MAX_STEP);
  localparam logic signed [W:0]   STEP_W     = (W + 1)'(MAX_STEP);
  localparam logic [DW-1:0]       DWELL_LOAD = DW'(DWELL_TICKS);

  logic                  tick;
  logic [1:0]            state, state_nxt;
  logic signed [W-1:0]   cur, cur_nxt;
  logic [DW-1:0]         dwell_cnt, dwell_nxt;
  logic signed [W-1:0]   eff, goal, stepped;
  logic signed [W:0]     diff;
  logic                  opposite;
  logic [W-1:0]          speed_q;
  logic                  dir_q, run_en_q, at_target_q;

  tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    eff = '0;
    if (bus.enable) eff = (bus.target < -LIM) ? -LIM : bus.target;

    // a reversal first slews to zero; zero is never crossed in one tick
    opposite = (cur != '0) && (eff != '0) && (cur[W-1] != eff[W-1]);
    goal     = opposite ? '0 : eff;
    diff     = $signed({goal[W-1], goal}) - $signed({cur[W-1], cur});

    if (diff > STEP_W)       stepped = cur + STEP_N;
    else if (diff < -STEP_W) stepped = cur - STEP_N;
    else                     stepped = goal;

    state_nxt = state;
    cur_nxt   = cur;
    dwell_nxt = dwell_cnt;

    if (bus.estop) begin
      state_nxt = S_ESTOP;
      cur_nxt   = '0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (eff != '0) begin
            state_nxt = S_RAMP;
            cur_nxt   = stepped;
          end
        end
        S_RAMP: begin
          cur_nxt = stepped;
          if (stepped == '0) begin
            state_nxt = S_DWELL;
            dwell_nxt = DWELL_LOAD;
          end
        end
        S_DWELL: begin
          if (dwell_cnt <= DW'(1)) begin
            state_nxt = S_IDLE;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt - DW'(1);
          end
        end
        S_ESTOP: begin
          state_nxt = S_DWELL;
          dwell_nxt = DWELL_LOAD;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      dwell_cnt   <= '0;
      speed_q     <= '0;
      dir_q       <= DIR_FWD;
      run_en_q    <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      dwell_cnt   <= dwell_nxt;
      speed_q     <= cur_nxt[W-1] ? $unsigned(-cur_nxt) : $unsigned(cur_nxt);
      if (cur_nxt != '0) dir_q <= ~cur_nxt[W-1];
      run_en_q    <= (cur_nxt != '0);
      at_target_q <= (cur_nxt == eff);
    end
  end

  assign bus.speed     = speed_q;
  assign bus.dir       = dir_q;
  assign bus.run_en    = run_en_q;
  assign bus.at_target = at_target_q;
  assign bus.tick      = tick;

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Scoreboard bench for motor_speed_ramp against an integer reference model.
module tb_motor_speed_ramp;
  import motor_pkg::*;

  localparam int TD = 4;
  localparam int MS = 8;
  localparam int DT = 2;

  typedef struct {
    int speed;
    bit dir;
    bit run_en;
    bit at_target;
    bit tick;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  motor_speed_ramp_if bus ();

  motor_speed_ramp #(.TICK_DIV(TD), .MAX_STEP(MS), .DWELL_TICKS(DT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int m_div, m_cur, m_dwell;
  bit m_estop, m_dir;

  task automatic model_reset();
    m_div = 0; m_cur = 0; m_dwell = 0; m_estop = 0; m_dir = 1;
  endtask

  task automatic check_direct(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // drive one clock of inputs at a negedge and queue the state the next posedge must produce
  task automatic step(input bit en, input bit es, input int tgt);
    exp_t e;
    int eff, goal, prev;
    bit tick_now;
    bus.enable = en;
    bus.estop  = es;
    bus.target = 10'(tgt);
    eff = en ? ((tgt < -511) ? -511 : tgt) : 0;
    tick_now = (m_div == TD - 1);
    m_div = (m_div + 1) % TD;
    if (es) begin
      m_cur = 0;
      m_estop = 1;
    end else if (tick_now) begin
      if (m_estop) begin
        m_estop = 0;
        m_dwell = DT;
      end else if (m_dwell > 0) begin
        m_dwell--;
      end else begin
        prev = m_cur;
        goal = (m_cur * eff < 0) ? 0 : eff;
        if (goal > m_cur + MS)      m_cur = m_cur + MS;
        else if (goal < m_cur - MS) m_cur = m_cur - MS;
        else                        m_cur = goal;
        if (prev != 0 && m_cur == 0) m_dwell = DT;
      end
    end
    if (m_cur != 0) m_dir = (m_cur > 0);
    e.speed     = (m_cur < 0) ? -m_cur : m_cur;
    e.dir       = m_dir;
    e.run_en    = (m_cur != 0);
    e.at_target = (m_cur == eff);
    e.tick      = (m_div == TD - 1);
    q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (int'(bus.speed) != e.speed) begin
          miscompares++;
          $display("FAIL speed @%0t: got %0d expected %0d", $time, bus.speed, e.speed);
        end
        if (bus.dir !== e.dir) begin
          miscompares++;
          $display("FAIL dir @%0t: got %0b expected %0b", $time, bus.dir, e.dir);
        end
        if (bus.run_en !== e.run_en) begin
          miscompares++;
          $display("FAIL run_en @%0t: got %0b expected %0b", $time, bus.run_en, e.run_en);
        end
        if (bus.at_target !== e.at_target) begin
          miscompares++;
          $display("FAIL at_target @%0t: got %0b expected %0b", $time, bus.at_target, e.at_target);
        end
        if (bus.tick !== e.tick) begin
          miscompares++;
          $display("FAIL tick @%0t: got %0b expected %0b", $time, bus.tick, e.tick);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog @%0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    bit en, es;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.estop  = 1'b0;
    bus.target = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_direct("rst_speed", int'(bus.speed), 0);
    check_direct("rst_dir", int'(bus.dir), 1);
    check_direct("rst_run_en", int'(bus.run_en), 0);
    check_direct("rst_at_target", int'(bus.at_target), 1);
    check_direct("rst_tick", int'(bus.tick), 0);
    reset = 1'b0;

    repeat (10)      step(0, 0, 0);
    repeat (TD * 6)  step(1, 0, 20);
    repeat (TD * 10) step(1, 0, -12);
    repeat (TD * 20) step(1, 0, 100);
    step(1, 1, 100);
    repeat (TD * 20) step(1, 0, 100);
    repeat (TD * 3)  step(1, 1, 100);
    repeat (TD * 8)  step(0, 0, 100);
    repeat (TD * 90) step(1, 0, -512);
    repeat (TD * 10) step(0, 0, -512);

    tgt = 0; en = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        tgt = int'($urandom_range(0, 1023)) - 512;
        en  = ($urandom_range(0, 7) != 0);
      end
      es = ($urandom_range(0, 60) == 0);
      step(en, es, tgt);
    end

    repeat (400) step(1, 0, -40);
    @(posedge clock);
    #2;
    check_direct("pre_rst_speed", int'(bus.speed), 40);
    check_direct("pre_rst_dir", int'(bus.dir), 0);
    #1 reset = 1'b1;
    #1;
    check_direct("async_rst_speed", int'(bus.speed), 0);
    check_direct("async_rst_dir", int'(bus.dir), 1);
    check_direct("async_rst_run_en", int'(bus.run_en), 0);
    check_direct("async_rst_at_target", int'(bus.at_target), 1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (TD * 10) step(1, 0, -40);

    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clock);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
